// File: rtl/tx_frame_arbiter.sv
// Two-source AXI-Stream frame arbiter: sync frames (s0) win over data frames (s1),
// bounded by P_SYNC_BURST, with optional post-frame idle gap. Stats enabled by `TX_ARB_STATS_EN.
module tx_frame_arbiter #(
  parameter int unsigned P_SYNC_BURST = 4,
  parameter int unsigned P_IDLE_GAP   = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stat_rx_status,
  input  logic        s0_axis_tvalid,
  output logic        s0_axis_tready,
  input  logic [63:0] s0_axis_tdata,
  input  logic        s0_axis_tlast,
  input  logic [7:0]  s0_axis_tkeep,
  input  logic        s1_axis_tvalid,
  output logic        s1_axis_tready,
  input  logic [63:0] s1_axis_tdata,
  input  logic        s1_axis_tlast,
  input  logic [7:0]  s1_axis_tkeep,
  output logic        o_tx_axis_tvalid,
  output logic [63:0] o_tx_axis_tdata,
  output logic        o_tx_axis_tlast,
  output logic [7:0]  o_tx_axis_tkeep,
  output logic        o_tx_axis_tuser,
  input  logic        i_tx_axis_tready,
  output logic [1:0]  o_grant,
  output logic [31:0] o_sync_frame_cnt,
  output logic [31:0] o_data_frame_cnt
);
  typedef enum logic [1:0] {IDLE, GRANT_S0, GRANT_S1, GAP} state_t;

  localparam logic [7:0] BURST_MAX   = 8'(P_SYNC_BURST);
  localparam logic [3:0] GAP_LAST    = (P_IDLE_GAP > 0) ? 4'(P_IDLE_GAP - 1) : 4'd0;
  localparam state_t     AFTER_FRAME = (P_IDLE_GAP > 0) ? GAP : IDLE;

  state_t     state;
  logic [7:0] burst_cnt;
  logic [3:0] gap_cnt;
  logic       burst_full;
  logic       s0_done;
  logic       s1_done;

  assign burst_full = (burst_cnt == BURST_MAX);
  assign s0_done    = (state == GRANT_S0) && s0_axis_tvalid && i_tx_axis_tready && s0_axis_tlast;
  assign s1_done    = (state == GRANT_S1) && s1_axis_tvalid && i_tx_axis_tready && s1_axis_tlast;

  // o_grant is registered alongside the state so the mux select never glitches
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      o_grant   <= 2'b00;
      burst_cnt <= 8'd0;
      gap_cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!s1_axis_tvalid) burst_cnt <= 8'd0;
          if (i_stat_rx_status && s0_axis_tvalid && !(burst_full && s1_axis_tvalid)) begin
            state   <= GRANT_S0;
            o_grant <= 2'b01;
          end else if (i_stat_rx_status && s1_axis_tvalid) begin
            state   <= GRANT_S1;
            o_grant <= 2'b10;
          end
        end
        GRANT_S0: begin
          if (s0_done) begin
            if (!burst_full) burst_cnt <= burst_cnt + 8'd1;
            state   <= AFTER_FRAME;
            o_grant <= 2'b00;
          end
        end
        GRANT_S1: begin
          if (s1_done) begin
            burst_cnt <= 8'd0;
            state     <= AFTER_FRAME;
            o_grant   <= 2'b00;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= 4'd0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          o_grant <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    o_tx_axis_tvalid = 1'b0;
    o_tx_axis_tdata  = 64'd0;
    o_tx_axis_tlast  = 1'b0;
    o_tx_axis_tkeep  = 8'd0;
    s0_axis_tready   = 1'b0;
    s1_axis_tready   = 1'b0;
    if (o_grant[0]) begin
      o_tx_axis_tvalid = s0_axis_tvalid;
      o_tx_axis_tdata  = s0_axis_tdata;
      o_tx_axis_tlast  = s0_axis_tlast;
      o_tx_axis_tkeep  = s0_axis_tkeep;
      s0_axis_tready   = i_tx_axis_tready;
    end else if (o_grant[1]) begin
      o_tx_axis_tvalid = s1_axis_tvalid;
      o_tx_axis_tdata  = s1_axis_tdata;
      o_tx_axis_tlast  = s1_axis_tlast;
      o_tx_axis_tkeep  = s1_axis_tkeep;
      s1_axis_tready   = i_tx_axis_tready;
    end
  end

  assign o_tx_axis_tuser = 1'b0;

`ifdef TX_ARB_STATS_EN
  logic [31:0] sync_cnt;
  logic [31:0] data_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_cnt <= 32'd0;
      data_cnt <= 32'd0;
    end else begin
      if (s0_done) sync_cnt <= sync_cnt + 32'd1;
      if (s1_done) data_cnt <= data_cnt + 32'd1;
    end
  end

  assign o_sync_frame_cnt = sync_cnt;
  assign o_data_frame_cnt = data_cnt;
`else
  assign o_sync_frame_cnt = 32'd0;
  assign o_data_frame_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: instance 0 (no idle gap) and instance 1 (3-cycle gap) see the
// same scenarios; an owner/gap/burst model predicts every output on every cycle.
`timescale 1ns/1ps
module tb_tx_frame_arbiter;
  localparam int NI    = 2;
  localparam int BURST = 4;
  localparam int CONT  = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic link = 1'b0;
  logic tx_ready = 1'b1;
  bit   toggle_ready = 1'b0;

  always #5 clk = ~clk;

  logic        s_tvalid [NI][2];
  logic        s_tready [NI][2];
  logic [63:0] s_tdata  [NI][2];
  logic        s_tlast  [NI][2];
  logic [7:0]  s_tkeep  [NI][2];
  logic        o_tvalid [NI];
  logic [63:0] o_tdata  [NI];
  logic        o_tlast  [NI];
  logic [7:0]  o_tkeep  [NI];
  logic        o_tuser  [NI];
  logic [1:0]  o_grant  [NI];
  logic [31:0] o_scnt   [NI];
  logic [31:0] o_dcnt   [NI];

  tx_frame_arbiter #(.P_SYNC_BURST(BURST), .P_IDLE_GAP(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_stat_rx_status(link),
    .s0_axis_tvalid(s_tvalid[0][0]), .s0_axis_tready(s_tready[0][0]), .s0_axis_tdata(s_tdata[0][0]),
    .s0_axis_tlast(s_tlast[0][0]), .s0_axis_tkeep(s_tkeep[0][0]),
    .s1_axis_tvalid(s_tvalid[0][1]), .s1_axis_tready(s_tready[0][1]), .s1_axis_tdata(s_tdata[0][1]),
    .s1_axis_tlast(s_tlast[0][1]), .s1_axis_tkeep(s_tkeep[0][1]),
    .o_tx_axis_tvalid(o_tvalid[0]), .o_tx_axis_tdata(o_tdata[0]), .o_tx_axis_tlast(o_tlast[0]),
    .o_tx_axis_tkeep(o_tkeep[0]), .o_tx_axis_tuser(o_tuser[0]), .i_tx_axis_tready(tx_ready),
    .o_grant(o_grant[0]), .o_sync_frame_cnt(o_scnt[0]), .o_data_frame_cnt(o_dcnt[0])
  );

  tx_frame_arbiter #(.P_SYNC_BURST(BURST), .P_IDLE_GAP(3)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_stat_rx_status(link),
    .s0_axis_tvalid(s_tvalid[1][0]), .s0_axis_tready(s_tready[1][0]), .s0_axis_tdata(s_tdata[1][0]),
    .s0_axis_tlast(s_tlast[1][0]), .s0_axis_tkeep(s_tkeep[1][0]),
    .s1_axis_tvalid(s_tvalid[1][1]), .s1_axis_tready(s_tready[1][1]), .s1_axis_tdata(s_tdata[1][1]),
    .s1_axis_tlast(s_tlast[1][1]), .s1_axis_tkeep(s_tkeep[1][1]),
    .o_tx_axis_tvalid(o_tvalid[1]), .o_tx_axis_tdata(o_tdata[1]), .o_tx_axis_tlast(o_tlast[1]),
    .o_tx_axis_tkeep(o_tkeep[1]), .o_tx_axis_tuser(o_tuser[1]), .i_tx_axis_tready(tx_ready),
    .o_grant(o_grant[1]), .o_sync_frame_cnt(o_scnt[1]), .o_data_frame_cnt(o_dcnt[1])
  );

  // source generators: frames left to send, frame length, current beat, frame serial
  int src_left [NI][2];
  int src_len  [NI][2];
  int src_beat [NI][2];
  int src_fnum [NI][2];

  // model: owner 0 = none, 1 = s0, 2 = s1; gap cycles still to wait; sync frames in a row
  int          m_owner  [NI];
  int          m_gap    [NI];
  int          m_burst  [NI];
  logic [31:0] m_frames [NI][2];

  int hs_cnt [NI][2];
  int last_end [NI];
  int gap_meas [NI];
  int glog [$];
  int cyc = 0;
  int ntests = 0;
  int nfail = 0;

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [63:0] beat_data(input int k, input int j, input int f, input int b);
    return {8'hC0 + 8'(j), 8'(k), 16'(f), 16'(b), 16'hBEEF ^ 16'(f * 7 + b)};
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic bound_chk(input string nm, input bit ok);
    ntests++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s: cycle budget expired at cyc%0d", nm, cyc);
    end
  endtask

  task automatic set_src(input int j, input int len, input int left);
    for (int k = 0; k < NI; k++) begin
      src_len[k][j]  = len;
      src_left[k][j] = left;
    end
  endtask

  task automatic drive_sources();
    for (int k = 0; k < NI; k++)
      for (int j = 0; j < 2; j++) begin
        s_tvalid[k][j] = (src_left[k][j] > 0);
        s_tdata[k][j]  = beat_data(k, j, src_fnum[k][j], src_beat[k][j]);
        s_tlast[k][j]  = (src_beat[k][j] == src_len[k][j] - 1);
        s_tkeep[k][j]  = s_tlast[k][j] ? 8'h0F : 8'hFF;
      end
  endtask

  task automatic model_reset(input int k);
    m_owner[k] = 0;
    m_gap[k] = 0;
    m_burst[k] = 0;
    m_frames[k][0] = 32'd0;
    m_frames[k][1] = 32'd0;
  endtask

  task automatic check_outputs(input int k);
    int j;
    logic [31:0] e0, e1;
    j = m_owner[k] - 1;
    chk("grant", k, 64'(o_grant[k]), (m_owner[k] == 1) ? 64'd1 : (m_owner[k] == 2) ? 64'd2 : 64'd0);
    chk("tvalid", k, 64'(o_tvalid[k]), (j >= 0) ? 64'(s_tvalid[k][j]) : 64'd0);
    chk("tdata", k, o_tdata[k], (j >= 0) ? s_tdata[k][j] : 64'd0);
    chk("tlast", k, 64'(o_tlast[k]), (j >= 0) ? 64'(s_tlast[k][j]) : 64'd0);
    chk("tkeep", k, 64'(o_tkeep[k]), (j >= 0) ? 64'(s_tkeep[k][j]) : 64'd0);
    chk("tuser", k, 64'(o_tuser[k]), 64'd0);
    chk("s0_tready", k, 64'(s_tready[k][0]), 64'((m_owner[k] == 1) && tx_ready));
    chk("s1_tready", k, 64'(s_tready[k][1]), 64'((m_owner[k] == 2) && tx_ready));
`ifdef TX_ARB_STATS_EN
    e0 = m_frames[k][0];
    e1 = m_frames[k][1];
`else
    e0 = 32'd0;
    e1 = 32'd0;
`endif
    chk("sync_cnt", k, 64'(o_scnt[k]), 64'(e0));
    chk("data_cnt", k, 64'(o_dcnt[k]), 64'(e1));
  endtask

  task automatic model_step(input int k);
    int j;
    bit v0, v1;
    if (m_owner[k] != 0) begin
      j = m_owner[k] - 1;
      if (s_tvalid[k][j] && tx_ready && s_tlast[k][j]) begin
        m_frames[k][j] = m_frames[k][j] + 32'd1;
        m_burst[k] = (j == 0) ? ((m_burst[k] < BURST) ? m_burst[k] + 1 : BURST) : 0;
        m_owner[k] = 0;
        m_gap[k] = gap_of(k);
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end else begin
      v0 = s_tvalid[k][0];
      v1 = s_tvalid[k][1];
      if (link && v0 && !(m_burst[k] == BURST && v1)) m_owner[k] = 1;
      else if (link && v1) m_owner[k] = 2;
      if (!v1) m_burst[k] = 0;
      if (k == 0 && m_owner[k] != 0) glog.push_back(m_owner[k]);
    end
  endtask

  // source side reacts to the DUT's own handshakes, as a real AXI master would
  task automatic observe(input int k);
    for (int j = 0; j < 2; j++)
      if (s_tvalid[k][j] && s_tready[k][j]) begin
        hs_cnt[k][j]++;
        if (src_beat[k][j] == 0 && last_end[k] >= 0) gap_meas[k] = cyc - last_end[k] - 1;
        if (s_tlast[k][j]) begin
          last_end[k] = cyc;
          src_beat[k][j] = 0;
          src_fnum[k][j]++;
          src_left[k][j]--;
        end else begin
          src_beat[k][j]++;
        end
      end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (rst) model_reset(k);
      check_outputs(k);
      if (!rst) begin
        model_step(k);
        observe(k);
      end
    end
    @(posedge clk);
    #1;
    tx_ready = toggle_ready ? ~tx_ready : 1'b1;
    drive_sources();
  endtask

  task automatic clear_stats();
    for (int k = 0; k < NI; k++) begin
      hs_cnt[k][0] = 0;
      hs_cnt[k][1] = 0;
      last_end[k] = -1;
      gap_meas[k] = -1;
    end
    glog.delete();
  endtask

  // asserts reset just after an edge; outputs must fall before any further edge
  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      src_beat[k][0] = 0;
      src_beat[k][1] = 0;
    end
    drive_sources();
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_grant", k, 64'(o_grant[k]), 64'd0);
      chk("rst_tvalid", k, 64'(o_tvalid[k]), 64'd0);
      chk("rst_treadys", k, 64'({s_tready[k][0], s_tready[k][1]}), 64'd0);
      chk("rst_cnts", k, {o_scnt[k], o_dcnt[k]}, 64'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    clear_stats();
  endtask

  initial begin
    int n;
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < 2; j++) begin
        src_left[k][j] = 0;
        src_len[k][j] = 1;
        src_beat[k][j] = 0;
        src_fnum[k][j] = 0;
      end
      model_reset(k);
    end
    drive_sources();

    // continuous 3-beat sync frames, data source idle
    set_src(0, 3, CONT);
    link = 1'b1;
    do_reset();
    repeat (40) tick();
    chk("a_grants", 0, 64'(glog.size()), 64'd10);
    n = 0;
    foreach (glog[i]) if (glog[i] != 1) n++;
    chk("a_only_s0", 0, 64'(n), 64'd0);
    chk("a_idle_between", 0, 64'(gap_meas[0]), 64'd1);
    chk("a_gap3_between", 1, 64'(gap_meas[1]), 64'd4);

    // both continuous: 4 sync frames then 1 data frame, repeating
    set_src(0, 2, CONT);
    set_src(1, 3, CONT);
    do_reset();
    n = 0;
    while (int'(m_frames[0][0] + m_frames[0][1]) < 50 && n < 400) begin
      tick();
      n++;
    end
    bound_chk("b_50_frames", int'(m_frames[0][0] + m_frames[0][1]) >= 50);
    tick();
    chk("b_model_s0", 0, 64'(m_frames[0][0]), 64'd40);
    chk("b_model_s1", 0, 64'(m_frames[0][1]), 64'd10);
`ifdef TX_ARB_STATS_EN
    chk("b_sync_cnt", 0, 64'(o_scnt[0]), 64'd40);
    chk("b_data_cnt", 0, 64'(o_dcnt[0]), 64'd10);
`else
    chk("b_sync_cnt", 0, 64'(o_scnt[0]), 64'd0);
    chk("b_data_cnt", 0, 64'(o_dcnt[0]), 64'd0);
`endif
    n = 0;
    for (int i = 0; i < 10; i++) if (glog[i] != (((i % 5) == 4) ? 2 : 1)) n++;
    chk("b_pattern", 0, 64'(n), 64'd0);

    // one 5-beat data frame under toggling tready; sync arrives mid-frame
    set_src(0, 3, 0);
    set_src(1, 5, 1);
    toggle_ready = 1'b1;
    do_reset();
    n = 0;
    while (m_owner[0] != 2 && n < 10) begin
      tick();
      n++;
    end
    bound_chk("c_s1_grant", m_owner[0] == 2);
    set_src(0, 3, CONT);
    drive_sources();
    n = 0;
    while (hs_cnt[0][1] < 5 && n < 40) begin
      tick();
      n++;
    end
    bound_chk("c_s1_done", hs_cnt[0][1] == 5);
    chk("c_s0_beats_during", 0, 64'(hs_cnt[0][0]), 64'd0);
    chk("c_grant_log", 0, 64'(glog.size()), 64'd1);
    repeat (10) tick();
    chk("c_s1_total", 0, 64'(hs_cnt[0][1]), 64'd5);
    chk("c_s0_after", 0, 64'(hs_cnt[0][0] > 0), 64'd1);
    toggle_ready = 1'b0;

    // link drops after first beat of a 4-beat sync frame
    set_src(0, 4, CONT);
    set_src(1, 2, CONT);
    do_reset();
    n = 0;
    while (hs_cnt[0][0] < 1 && n < 10) begin
      tick();
      n++;
    end
    bound_chk("d_first_beat", hs_cnt[0][0] == 1);
    link = 1'b0;
    repeat (12) tick();
    chk("d_frame_finished", 0, 64'(hs_cnt[0][0]), 64'd4);
    chk("d_no_s1", 0, 64'(hs_cnt[0][1]), 64'd0);
    chk("d_grant_none", 0, 64'(o_grant[0]), 64'd0);
    chk("d_grant_none", 1, 64'(o_grant[1]), 64'd0);
    link = 1'b1;
    repeat (10) tick();
    chk("d_resumed", 0, 64'(hs_cnt[0][0] > 4), 64'd1);

    // reset while the data source owns the link mid-frame
    set_src(0, 2, CONT);
    set_src(1, 4, CONT);
    do_reset();
    n = 0;
    while (!(m_owner[0] == 2 && src_beat[0][1] >= 1) && n < 60) begin
      tick();
      n++;
    end
    bound_chk("e_mid_s1", m_owner[0] == 2);
    chk("e_pre_grant", 0, 64'(o_grant[0]), 64'd2);
    do_reset();
    repeat (20) tick();
    chk("e_first_after", 0, 64'(glog.size() > 0 ? glog[0] : 0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
